cdb_sched: RTL and testbench
============================

// Module: cdb_sched
// PURPOSE
// - Completion scheduler in front of the N-lane CDB broadcast: buffers finished FU results and shares CDB lanes fairly.
// - Each FU gets a private DEPTH-entry FIFO; up to N queue heads are granted per cycle using round-robin order.
// - Winners are driven as registered lane bundles (valid/tag/data) to the CDB, RS and map-table consumers.
// - Ready-based backpressure stalls an FU only when its own queue is full. Results are never dropped.
// PARAMETERS
// - N       `N                        CDB lanes broadcast per cycle (1..NUM_FU)
// - NUM_FU  `NUM_FU_ALU+`NUM_FU_MULT  result producers
// - DEPTH   2                         entries per FU queue (>=1)
// PORTS
// - clock          in   1              rising-edge clock
// - reset          in   1              synchronous, active-high
// - flush          in   1              squash all buffered and in-flight results (mispredict recovery)
// - fu_valid       in   NUM_FU         FU i presents a result this cycle
// - fu_tag         in   NUM_FU*PHYS_TAG  destination physical tag per FU
// - fu_data        in   NUM_FU*DATA    result value per FU
// - fu_ready       out  NUM_FU         FU i queue can accept this cycle
// - cdb_valid      out  N              lane valid (registered)
// - cdb_tag        out  N*PHYS_TAG     lane tag (registered)
// - cdb_data       out  N*DATA         lane data (registered)
// - cdb_grant_mask out  NUM_FU         FUs whose head was broadcast this cycle (registered)
// - cdb_grant_cnt  out  $clog2(N+1)    popcount of cdb_grant_mask
// BEHAVIOUR
// - Reset values: all queues empty; rr_ptr=0; cdb_valid, cdb_grant_mask and cdb_grant_cnt are 0; cdb_tag and cdb_data are 0; fu_ready is all 1s.
// - Per-FU state: DEPTH-entry circular FIFO with head and tail pointers (wrap at DEPTH) and a count of width $clog2(DEPTH+1).
// - fu_ready[i] = (count[i] < DEPTH) and !flush.
//   - It depends on the registered count only. There is no credit for a same-cycle pop.
// - Enqueue: when fu_valid[i] && fu_ready[i], the entry is written at the clock edge.
//   - fu_valid && !fu_ready is a protocol violation. It triggers an assertion, and the queue is left unchanged.
// - Eligibility: FU i is eligible when count[i]!=0, using the registered count. An entry enqueued at edge K is first eligible in cycle K+1.
// - Arbitration (comb):
//   - Scan FUs in order rr_ptr, rr_ptr+1, ... mod NUM_FU.
//   - The first N eligible FUs win lanes 0..N-1 in scan order.
//   - Unused lanes are invalid.
// - Pop: each winner's head is dequeued at the edge.
//   - Push and pop on the same FU in the same cycle are both performed, and the count is unchanged.
// - Output register: the winners' head tag/data are latched at the edge into cdb_* together with grant_mask and grant_cnt.
//   - Latency: fu_valid in cycle K gives cdb_valid in cycle K+2 at minimum.
// - Round-robin pointer update:
//   - If there was at least one grant: rr_ptr <= (index of the last-granted FU + 1) mod NUM_FU.
//   - Otherwise rr_ptr holds.
//   - Bound: every non-empty head is broadcast within ceil(NUM_FU/N) cycles.
// - Ordering:
//   - Per-FU order is FIFO.
//   - No ordering is guaranteed across FUs.
//   - Lane order follows scan order.
// - Flush (synchronous, priority over everything):
//   - At the edge, all queues are emptied and cdb_valid, grant_mask and grant_cnt are cleared.
//   - rr_ptr is kept.
//   - Enqueues presented in the flush cycle are discarded.
//   - fu_ready is 0 during the flush cycle.
// - Reset asserted mid-operation behaves like flush plus rr_ptr=0 and all outputs zeroed.
// - Invalid lanes drive tag=0 and data=0.
// - Assertions:
//   - At most one lane per FU.
//   - Grant count <= N.
//   - No pop from an empty queue.
// TESTING
// - Single result: N=2, fu_valid[3]=1 with tag=7, data=0xAB for 1 cycle -> cdb_valid=01, cdb_tag[0]=7, cdb_data[0]=0xAB two cycles later; grant_mask=1<<3, grant_cnt=1.
// - Contention: N=2, NUM_FU=4, all FUs push one result in cycle 0 with rr_ptr=0 -> cycle 2: FUs 0,1 granted; cycle 3: FUs 2,3 granted; rr_ptr returns to 0.
// - Fairness: FUs 0 and 1 push every cycle, N=1 -> grants alternate 0,1,0,1...; FU 1 is never skipped twice in a row.
// - Backpressure: DEPTH=2, N=1, FUs 0 and 1 push 3 results each back-to-back -> fu_ready[1] drops after 2 enqueues; all 6 results appear with per-FU FIFO order intact, and the assertion never fires.
// - Flush: 3 results queued, flush pulsed with fu_valid[0]=1 in the same cycle -> next cycle cdb_valid=0; all counts 0; no queued or flush-cycle result is ever broadcast.
// - Same-cycle push and pop: a full queue on FU 2 is granted while FU 2 pushes -> the count stays DEPTH and data order is preserved.

Source files
------------

// File: rtl/cdb_sched.sv
// Completion scheduler: per-FU result FIFOs feeding N round-robin-arbitrated CDB lanes.
module cdb_sched #(
  parameter int unsigned N        = 2,
  parameter int unsigned NUM_FU   = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PHYS_TAG = 6,
  parameter int unsigned DATA     = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  input  logic [NUM_FU*PHYS_TAG-1:0]   fu_tag,
  input  logic [NUM_FU*DATA-1:0]       fu_data,
  output logic [NUM_FU-1:0]            fu_ready,
  output logic [N-1:0]                 cdb_valid,
  output logic [N*PHYS_TAG-1:0]        cdb_tag,
  output logic [N*DATA-1:0]            cdb_data,
  output logic [NUM_FU-1:0]            cdb_grant_mask,
  output logic [$clog2(N+1)-1:0]       cdb_grant_cnt
);

  localparam int unsigned FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned LANE_W = $clog2(N + 1);
  localparam int unsigned SCAN_W = FU_W + 1;

  logic [PHYS_TAG-1:0] mem_tag  [NUM_FU][DEPTH];
  logic [DATA-1:0]     mem_data [NUM_FU][DEPTH];
  logic [PTR_W-1:0]    head     [NUM_FU];
  logic [PTR_W-1:0]    tail     [NUM_FU];
  logic [CNT_W-1:0]    count    [NUM_FU];
  logic [FU_W-1:0]     rr_ptr;

  logic [NUM_FU-1:0]   push_c;
  logic [NUM_FU-1:0]   grant_c;
  logic [LANE_W-1:0]   lanes_c;
  logic [FU_W-1:0]     last_c;
  logic [SCAN_W-1:0]   scan_c;
  logic [N-1:0]        lane_valid_c;
  logic [PHYS_TAG-1:0] lane_tag_c  [N];
  logic [DATA-1:0]     lane_data_c [N];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready comes from the registered occupancy only; a same-cycle pop gives no credit.
  always_comb begin
    fu_ready = '0;
    push_c   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] < CNT_W'(DEPTH)) && !flush;
      push_c[i]   = fu_valid[i] && fu_ready[i];
    end
  end

  // Round-robin scan from rr_ptr; the first N non-empty queues take lanes in scan order.
  always_comb begin
    grant_c      = '0;
    lanes_c      = '0;
    last_c       = '0;
    scan_c       = '0;
    lane_valid_c = '0;
    for (int l = 0; l < N; l++) begin
      lane_tag_c[l]  = '0;
      lane_data_c[l] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      scan_c = SCAN_W'(rr_ptr) + SCAN_W'(k);
      if (scan_c >= SCAN_W'(NUM_FU)) begin
        scan_c = scan_c - SCAN_W'(NUM_FU);
      end
      if ((count[scan_c[FU_W-1:0]] != '0) && (lanes_c < LANE_W'(N))) begin
        grant_c[scan_c[FU_W-1:0]] = 1'b1;
        for (int l = 0; l < N; l++) begin
          if (LANE_W'(l) == lanes_c) begin
            lane_valid_c[l] = 1'b1;
            lane_tag_c[l]   = mem_tag[scan_c[FU_W-1:0]][head[scan_c[FU_W-1:0]]];
            lane_data_c[l]  = mem_data[scan_c[FU_W-1:0]][head[scan_c[FU_W-1:0]]];
          end
        end
        last_c  = scan_c[FU_W-1:0];
        lanes_c = lanes_c + LANE_W'(1);
      end
    end
  end

  // Queue storage: written on accepted enqueue, no reset needed since count guards reads.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_c[i] && !reset) begin
        mem_tag[i][tail[i]]  <= fu_tag[i*PHYS_TAG +: PHYS_TAG];
        mem_data[i][tail[i]] <= fu_data[i*DATA +: DATA];
      end
    end
  end

  // Queue pointers, round-robin pointer and registered CDB lane bundles.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr         <= '0;
      cdb_valid      <= '0;
      cdb_tag        <= '0;
      cdb_data       <= '0;
      cdb_grant_mask <= '0;
      cdb_grant_cnt  <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      cdb_valid      <= '0;
      cdb_tag        <= '0;
      cdb_data       <= '0;
      cdb_grant_mask <= '0;
      cdb_grant_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push_c[i]) begin
          tail[i] <= ptr_inc(tail[i]);
        end
        if (grant_c[i]) begin
          head[i] <= ptr_inc(head[i]);
        end
        if (push_c[i] && !grant_c[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push_c[i] && grant_c[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      for (int l = 0; l < N; l++) begin
        cdb_valid[l]                      <= lane_valid_c[l];
        cdb_tag[l*PHYS_TAG +: PHYS_TAG]   <= lane_tag_c[l];
        cdb_data[l*DATA +: DATA]          <= lane_data_c[l];
      end
      cdb_grant_mask <= grant_c;
      cdb_grant_cnt  <= lanes_c;
      if (lanes_c != '0) begin
        rr_ptr <= (last_c == FU_W'(NUM_FU - 1)) ? '0 : last_c + FU_W'(1);
      end
    end
  end

  // Protocol and arbitration sanity checks.
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_chk
    a_push_full: assert property (@(posedge clock) disable iff (reset)
      !(fu_valid[gi] && !flush && !fu_ready[gi]))
      else $error("fu %0d presented a result while its queue was full", gi);
    a_pop_empty: assert property (@(posedge clock) disable iff (reset)
      !(grant_c[gi] && (count[gi] == '0)))
      else $error("fu %0d granted with an empty queue", gi);
  end

  a_grant_cnt: assert property (@(posedge clock) disable iff (reset)
    lanes_c <= LANE_W'(N))
    else $error("more grants than lanes");

  a_one_lane: assert property (@(posedge clock) disable iff (reset)
    $countones(grant_c) == int'(lanes_c))
    else $error("an FU holds more than one lane");

endmodule

// File: tb/tb_cdb_sched.sv
// Bench for cdb_sched: directed scenarios plus random traffic against a queue-based model.
module tb_cdb_sched;

  localparam int unsigned N      = 2;
  localparam int unsigned NUM_FU = 4;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned PT     = 6;
  localparam int unsigned DW     = 16;
  localparam int unsigned GW     = $clog2(N + 1);

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   flush = 1'b0;
  logic [NUM_FU-1:0]      fu_valid = '0;
  logic [NUM_FU*PT-1:0]   fu_tag = '0;
  logic [NUM_FU*DW-1:0]   fu_data = '0;
  logic [NUM_FU-1:0]      fu_ready;
  logic [N-1:0]           cdb_valid;
  logic [N*PT-1:0]        cdb_tag;
  logic [N*DW-1:0]        cdb_data;
  logic [NUM_FU-1:0]      cdb_grant_mask;
  logic [GW-1:0]          cdb_grant_cnt;

  cdb_sched #(.N(N), .NUM_FU(NUM_FU), .DEPTH(DEPTH), .PHYS_TAG(PT), .DATA(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .fu_valid       (fu_valid),
    .fu_tag         (fu_tag),
    .fu_data        (fu_data),
    .fu_ready       (fu_ready),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .cdb_grant_mask (cdb_grant_mask),
    .cdb_grant_cnt  (cdb_grant_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference state: one result queue per FU plus the round-robin start index.
  logic [PT+DW-1:0] mq [NUM_FU][$];
  int               rr_m = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, predict the edge, compare at the next falling edge.
  task automatic step(input logic rst, input logic fl, input logic [NUM_FU-1:0] v_in,
                      input logic [NUM_FU*PT-1:0] t_in, input logic [NUM_FU*DW-1:0] d_in);
    logic [NUM_FU-1:0] rdy;
    logic [NUM_FU-1:0] v;
    logic [N-1:0]      e_valid;
    logic [N*PT-1:0]   e_tag;
    logic [N*DW-1:0]   e_data;
    logic [NUM_FU-1:0] e_mask;
    logic [PT+DW-1:0]  ent;
    int                lanes;
    int                last;
    int                f;
    rdy = '0;
    v   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      rdy[i] = (mq[i].size() < DEPTH) && !fl;
      v[i]   = v_in[i] && (mq[i].size() < DEPTH) && !rst;
    end
    reset    = rst;
    flush    = fl;
    fu_valid = v;
    fu_tag   = t_in;
    fu_data  = d_in;
    #1;
    check_eq("fu_ready", 64'(fu_ready), 64'(rdy));

    e_valid = '0;
    e_tag   = '0;
    e_data  = '0;
    e_mask  = '0;
    lanes   = 0;
    last    = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      f = (rr_m + k) % NUM_FU;
      if (mq[f].size() > 0 && lanes < N) begin
        ent = mq[f][0];
        e_valid[lanes]          = 1'b1;
        e_tag[lanes*PT +: PT]   = ent[PT+DW-1:DW];
        e_data[lanes*DW +: DW]  = ent[DW-1:0];
        e_mask[f]               = 1'b1;
        lanes++;
        last = f;
      end
    end
    if (rst || fl) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      if (rst) rr_m = 0;
      e_valid = '0;
      e_tag   = '0;
      e_data  = '0;
      e_mask  = '0;
      lanes   = 0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (e_mask[i]) void'(mq[i].pop_front());
        if (v[i]) mq[i].push_back({t_in[i*PT +: PT], d_in[i*DW +: DW]});
      end
      if (lanes > 0) rr_m = (last + 1) % NUM_FU;
    end

    @(negedge clock);
    check_eq("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    check_eq("cdb_tag", 64'(cdb_tag), 64'(e_tag));
    check_eq("cdb_data", 64'(cdb_data), 64'(e_data));
    check_eq("grant_mask", 64'(cdb_grant_mask), 64'(e_mask));
    check_eq("grant_cnt", 64'(cdb_grant_cnt), 64'(lanes));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [NUM_FU*PT-1:0] tv;
    logic [NUM_FU*DW-1:0] dv;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_valid", 64'(cdb_valid), 64'(0));
    check_eq("rst_tag", 64'(cdb_tag), 64'(0));
    check_eq("rst_data", 64'(cdb_data), 64'(0));
    check_eq("rst_mask", 64'(cdb_grant_mask), 64'(0));
    check_eq("rst_cnt", 64'(cdb_grant_cnt), 64'(0));
    check_eq("rst_ready", 64'(fu_ready), 64'(4'b1111));

    // Single result from FU 3: visible after the second edge.
    tv = '0; dv = '0;
    tv[3*PT +: PT] = PT'(7);
    dv[3*DW +: DW] = DW'(16'h00AB);
    step(1'b0, 1'b0, 4'b1000, tv, dv);
    check_eq("single_early", 64'(cdb_valid), 64'(0));
    idle();
    check_eq("single_valid", 64'(cdb_valid), 64'(2'b01));
    check_eq("single_tag", 64'(cdb_tag[PT-1:0]), 64'(7));
    check_eq("single_data", 64'(cdb_data[DW-1:0]), 64'(16'h00AB));
    check_eq("single_mask", 64'(cdb_grant_mask), 64'(4'b1000));
    check_eq("single_cnt", 64'(cdb_grant_cnt), 64'(1));

    // Contention: all four push once with rr at 0.
    for (int i = 0; i < NUM_FU; i++) begin
      tv[i*PT +: PT] = PT'(10 + i);
      dv[i*DW +: DW] = DW'(16'h100 + i);
    end
    step(1'b0, 1'b0, 4'b1111, tv, dv);
    idle();
    check_eq("cont_mask0", 64'(cdb_grant_mask), 64'(4'b0011));
    check_eq("cont_tag0", 64'(cdb_tag), 64'({PT'(11), PT'(10)}));
    idle();
    check_eq("cont_mask1", 64'(cdb_grant_mask), 64'(4'b1100));
    check_eq("cont_tag1", 64'(cdb_tag), 64'({PT'(13), PT'(12)}));
    idle();
    check_eq("cont_drain", 64'(cdb_valid), 64'(0));

    // Flush with three results queued and an enqueue in the flush cycle.
    step(1'b0, 1'b0, 4'b0111, tv, dv);
    step(1'b0, 1'b1, 4'b0001, tv, dv);
    check_eq("flush_valid", 64'(cdb_valid), 64'(0));
    for (int c = 0; c < 3; c++) begin
      idle();
      check_eq("flush_quiet", 64'(cdb_valid), 64'(0));
    end
    check_eq("flush_ready", 64'(fu_ready), 64'(4'b1111));

    // Sustained pressure: every FU pushes whenever it can, forcing full queues and push+pop.
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        tv[i*PT +: PT] = PT'(c * NUM_FU + i);
        dv[i*DW +: DW] = DW'(16'h2000 + c * 16 + i);
      end
      step(1'b0, 1'b0, 4'b1111, tv, dv);
    end
    repeat (4) idle();

    // Reset in the middle of traffic.
    step(1'b0, 1'b0, 4'b1111, tv, dv);
    step(1'b1, 1'b0, 4'b1111, tv, dv);
    check_eq("midrst_valid", 64'(cdb_valid), 64'(0));

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      logic rst_r;
      logic fl_r;
      logic [NUM_FU-1:0] v_r;
      rst_r = ($urandom_range(0, 199) == 0);
      fl_r  = ($urandom_range(0, 31) == 0);
      v_r   = NUM_FU'($urandom) | NUM_FU'($urandom);
      tv    = (NUM_FU*PT)'($urandom);
      dv    = {$urandom, $urandom};
      step(rst_r, fl_r, v_r, tv, dv);
    end
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
